// File: rtl/lock_timer.sv
// lock_timer: timing responder for the airlock interlock controller.
//
// Accepts fill, drain and wait request levels from the interlock FSM,
// runs one timed job at a time and raises the matching finished level once
// the programmed number of one-second ticks has elapsed. The finished level
// is held until the owning request drops.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset (wins over everything)
//   filling        fill request level
//   draining       drain request level
//   waiting        wait request level
//   fillFinished   fill job complete, held while filling stays high
//   drainFinished  drain job complete, held while draining stays high
//   waitFinished   wait job complete, held while waiting stays high
//   secsLeft       seconds remaining in the current job, 0 when idle
//   busy           high while a job is running or finished-and-held
//   conflict       sticky flag: two or more requests seen high together
//
// All outputs come straight from registers.
module lock_timer #(
    parameter int TICK_DIV   = 50000000,
    parameter int FILL_SECS  = 7,
    parameter int DRAIN_SECS = 8,
    parameter int WAIT_SECS  = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       filling,
    input  logic       draining,
    input  logic       waiting,
    output logic       fillFinished,
    output logic       drainFinished,
    output logic       waitFinished,
    output logic [3:0] secsLeft,
    output logic       busy,
    output logic       conflict
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
    localparam logic [3:0]    FILL_LOAD  = 4'(FILL_SECS);
    localparam logic [3:0]    DRAIN_LOAD = 4'(DRAIN_SECS);
    localparam logic [3:0]    WAIT_LOAD  = 4'(WAIT_SECS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FILL  = 2'd1,
        OWN_DRAIN = 2'd2,
        OWN_WAIT  = 2'd3
    } owner_t;

    // Finished-bit position for a given owner: [0]=fill, [1]=drain, [2]=wait.
    function automatic logic [2:0] finished_mask(input owner_t own);
        logic [2:0] mask;
        case (own)
            OWN_FILL:  mask = 3'b001;
            OWN_DRAIN: mask = 3'b010;
            OWN_WAIT:  mask = 3'b100;
            default:   mask = 3'b000;
        endcase
        return mask;
    endfunction

    state_t        state_r;
    state_t        state_next_s;
    owner_t        owner_r;
    owner_t        owner_next_s;
    logic [PW-1:0] prescale_r;
    logic [PW-1:0] prescale_next_s;
    logic [3:0]    secs_r;
    logic [3:0]    secs_next_s;
    logic [2:0]    finished_r;
    logic [2:0]    finished_next_s;
    logic          busy_r;
    logic          conflict_r;

    logic          owner_req_s;
    logic          any_req_s;
    logic          multi_req_s;
    logic          tick_s;

    assign any_req_s   = filling | draining | waiting;
    assign multi_req_s = (filling & draining) | (filling & waiting) | (draining & waiting);
    assign tick_s      = (prescale_r == TICK_LAST);

    // Level of the request that owns the current job.
    always_comb begin
        owner_req_s = 1'b0;
        case (owner_r)
            OWN_FILL:  owner_req_s = filling;
            OWN_DRAIN: owner_req_s = draining;
            OWN_WAIT:  owner_req_s = waiting;
            default:   owner_req_s = 1'b0;
        endcase
    end

    // State register plus the registered datapath and outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            owner_r    <= OWN_NONE;
            prescale_r <= '0;
            secs_r     <= 4'd0;
            finished_r <= 3'b000;
            busy_r     <= 1'b0;
            conflict_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            owner_r    <= owner_next_s;
            prescale_r <= prescale_next_s;
            secs_r     <= secs_next_s;
            finished_r <= finished_next_s;
            busy_r     <= (state_next_s != ST_IDLE);
            conflict_r <= conflict_r | multi_req_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Losing the owning request aborts, even on the final tick.
                if (!owner_req_s) begin
                    state_next_s = ST_IDLE;
                end else if (tick_s && (secs_r == 4'd1)) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                // Returning to IDLE here means a new request waits one cycle.
                if (!owner_req_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Next values for owner, prescaler, seconds counter and finished bits.
    always_comb begin
        owner_next_s    = owner_r;
        prescale_next_s = prescale_r;
        secs_next_s     = secs_r;
        finished_next_s = finished_r;
        case (state_r)
            ST_IDLE: begin
                prescale_next_s = '0;
                finished_next_s = 3'b000;
                // Priority when several requests arrive together: drain, fill, wait.
                if (draining) begin
                    owner_next_s = OWN_DRAIN;
                    secs_next_s  = DRAIN_LOAD;
                end else if (filling) begin
                    owner_next_s = OWN_FILL;
                    secs_next_s  = FILL_LOAD;
                end else if (waiting) begin
                    owner_next_s = OWN_WAIT;
                    secs_next_s  = WAIT_LOAD;
                end else begin
                    owner_next_s = OWN_NONE;
                    secs_next_s  = 4'd0;
                end
            end
            ST_RUN: begin
                if (!owner_req_s) begin
                    owner_next_s    = OWN_NONE;
                    prescale_next_s = '0;
                    secs_next_s     = 4'd0;
                    finished_next_s = 3'b000;
                end else if (tick_s) begin
                    // secs_r is at least 1 throughout RUN, so this never underflows.
                    prescale_next_s = '0;
                    secs_next_s     = secs_r - 4'd1;
                    if (secs_r == 4'd1) begin
                        finished_next_s = finished_mask(owner_r);
                    end else begin
                        finished_next_s = 3'b000;
                    end
                end else begin
                    prescale_next_s = prescale_r + {{(PW-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                if (!owner_req_s) begin
                    owner_next_s    = OWN_NONE;
                    prescale_next_s = '0;
                    secs_next_s     = 4'd0;
                    finished_next_s = 3'b000;
                end else begin
                    secs_next_s     = 4'd0;
                    finished_next_s = finished_mask(owner_r);
                end
            end
            default: begin
                owner_next_s    = OWN_NONE;
                prescale_next_s = '0;
                secs_next_s     = 4'd0;
                finished_next_s = 3'b000;
            end
        endcase
    end

    assign fillFinished  = finished_r[0];
    assign drainFinished = finished_r[1];
    assign waitFinished  = finished_r[2];
    assign secsLeft      = secs_r;
    assign busy          = busy_r;
    assign conflict      = conflict_r;

endmodule

// File: tb/tb_lock_timer.sv
// Scoreboard bench for lock_timer (TICK_DIV=4, FILL 7, DRAIN 8, WAIT 5).
// Stimulus drives inputs on the falling edge and queues the outputs it
// expects after the following rising edge; a monitor samples 1 time unit
// after each rising edge and checks queued entries due on that cycle.
module tb_lock_timer;

    logic       clk;
    logic       reset;
    logic       filling;
    logic       draining;
    logic       waiting;
    logic       fillFinished;
    logic       drainFinished;
    logic       waitFinished;
    logic [3:0] secsLeft;
    logic       busy;
    logic       conflict;

    lock_timer #(
        .TICK_DIV   (4),
        .FILL_SECS  (7),
        .DRAIN_SECS (8),
        .WAIT_SECS  (5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .filling       (filling),
        .draining      (draining),
        .waiting       (waiting),
        .fillFinished  (fillFinished),
        .drainFinished (drainFinished),
        .waitFinished  (waitFinished),
        .secsLeft      (secsLeft),
        .busy          (busy),
        .conflict      (conflict)
    );

    typedef struct {
        int         tgt;
        logic [8:0] val;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   n_check = 0;
    int   n_pass  = 0;

    localparam logic [8:0] ZERO = 9'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // {fillF, drainF, waitF, secsLeft, busy, conflict}
    function automatic logic [8:0] ex(input logic ff, input logic df, input logic wf,
                                      input logic [3:0] s, input logic b, input logic c);
        return {ff, df, wf, s, b, c};
    endfunction

    task automatic step(input logic r, input logic f, input logic d, input logic w,
                        input logic [8:0] e, input string nm);
        exp_t item;
        @(negedge clk);
        reset    = r;
        filling  = f;
        draining = d;
        waiting  = w;
        item.tgt = cyc + 1;
        item.val = e;
        item.nm  = nm;
        q.push_back(item);
    endtask

    task automatic step_n(input int n, input logic r, input logic f, input logic d,
                          input logic w, input logic [8:0] e, input string nm);
        for (int i = 0; i < n; i++) step(r, f, d, w, e, nm);
    endtask

    // Running job with the request held: 4 cycles per displayed second, dur down to 1.
    task automatic count_down(input logic f, input logic d, input logic w,
                              input int dur, input logic c, input string nm);
        for (int s = dur; s >= 1; s--) step_n(4, 1'b0, f, d, w, ex(1'b0, 1'b0, 1'b0, 4'(s), 1'b1, c), nm);
    endtask

    // Monitor: compare every expectation due on this cycle.
    initial begin
        exp_t e;
        logic [8:0] got;
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0 && q[0].tgt <= cyc) begin
                e = q.pop_front();
                got = {fillFinished, drainFinished, waitFinished, secsLeft, busy, conflict};
                n_check++;
                if (e.tgt != cyc) begin
                    $display("FAIL %s: stale entry for cycle %0d checked at %0d, got %b expected %b",
                             e.nm, e.tgt, cyc, got, e.val);
                end else if (got !== e.val) begin
                    $display("FAIL %s @cyc %0d: got %b expected %b (fF dF wF secs[4] busy conf)",
                             e.nm, cyc, got, e.val);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_check);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; filling = 1'b0; draining = 1'b0; waiting = 1'b0;

        step_n(2, 1'b1, 1'b0, 1'b0, 1'b0, ZERO, "reset");

        // Wait job: finished after edge 21, held, then released.
        count_down(1'b0, 1'b0, 1'b1, 5, 1'b0, "wait_run");
        step_n(3, 1'b0, 1'b0, 1'b0, 1'b1, ex(1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0), "wait_done");
        step(1'b0, 1'b0, 1'b0, 1'b0, ZERO, "wait_drop");
        step(1'b0, 1'b0, 1'b0, 1'b0, ZERO, "idle");

        // Drain job: finished after edge 33, held 10 more cycles.
        count_down(1'b0, 1'b1, 1'b0, 8, 1'b0, "drain_run");
        step_n(11, 1'b0, 1'b0, 1'b1, 1'b0, ex(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0), "drain_hold");

        // Filling rises on the drain-release edge: one idle cycle before it starts.
        step(1'b0, 1'b1, 1'b0, 1'b0, ZERO, "rearm_gap");
        // Fill held 10 cycles then dropped: abort.
        step_n(4, 1'b0, 1'b1, 1'b0, 1'b0, ex(1'b0, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0), "abort_run7");
        step_n(4, 1'b0, 1'b1, 1'b0, 1'b0, ex(1'b0, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0), "abort_run6");
        step_n(2, 1'b0, 1'b1, 1'b0, 1'b0, ex(1'b0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0), "abort_run5");
        step(1'b0, 1'b0, 1'b0, 1'b0, ZERO, "abort");
        step(1'b0, 1'b0, 1'b0, 1'b0, ZERO, "abort_idle");

        // Fresh fill restarts from 7 and completes.
        count_down(1'b1, 1'b0, 1'b0, 7, 1'b0, "fill_run");
        step(1'b0, 1'b1, 1'b0, 1'b0, ex(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0), "fill_done");
        step(1'b0, 1'b0, 1'b0, 1'b0, ZERO, "fill_drop");

        // Reset while secsLeft=3, request still high: restarts from 5.
        step_n(4, 1'b0, 1'b0, 1'b0, 1'b1, ex(1'b0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0), "rst_pre5");
        step_n(4, 1'b0, 1'b0, 1'b0, 1'b1, ex(1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0), "rst_pre4");
        step(1'b0, 1'b0, 1'b0, 1'b1, ex(1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0), "rst_pre3");
        step(1'b1, 1'b0, 1'b0, 1'b1, ZERO, "rst_mid");
        count_down(1'b0, 1'b0, 1'b1, 5, 1'b0, "rst_restart");
        step(1'b0, 1'b0, 1'b0, 1'b1, ex(1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0), "rst_restart_done");

        // Back-to-back: wait drops, fill rises the next cycle, done 29 edges later.
        step(1'b0, 1'b0, 1'b0, 1'b0, ZERO, "b2b_drop");
        count_down(1'b1, 1'b0, 1'b0, 7, 1'b0, "b2b_fill");
        step(1'b0, 1'b1, 1'b0, 1'b0, ex(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0), "b2b_fill_done");
        step(1'b0, 1'b0, 1'b0, 1'b0, ZERO, "b2b_release");

        // Simultaneous fill+drain: drain wins, conflict sticky until reset.
        step_n(4, 1'b0, 1'b1, 1'b1, 1'b0, ex(1'b0, 1'b0, 1'b0, 4'd8, 1'b1, 1'b1), "simul_run8");
        step_n(2, 1'b0, 1'b1, 1'b1, 1'b0, ex(1'b0, 1'b0, 1'b0, 4'd7, 1'b1, 1'b1), "simul_run7");
        step(1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1), "simul_drop");
        step_n(2, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1), "conflict_sticky");
        step(1'b1, 1'b0, 1'b0, 1'b0, ZERO, "conflict_reset");
        step(1'b0, 1'b0, 1'b0, 1'b0, ZERO, "post_reset");

        repeat (3) @(negedge clk);
        while (q.size() > 0) begin
            n_check++;
            $display("FAIL %s: expectation for cycle %0d never checked", q[0].nm, q[0].tgt);
            void'(q.pop_front());
        end
        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
